bus_request_arbiter: RTL and testbench
======================================

Name: bus_request_arbiter

Overview:
Schedules every bus cycle issued to the bus cycle engine in the bus control unit. Arbitrates between EU data-pointer requests, instruction prefetch and external hold (hldrq/hldak). Owns the prefetch pointer and decides when the instruction queue has room for another fetch. It discards a fetch that is in flight when the EU redirects the program flow.

Parameters:
QUEUE_DEPTH, 8, instruction queue capacity in bytes
FETCH_MIN_FREE, 2, minimum free queue bytes before a fetch is scheduled

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ce_1  in  1  phase-1 clock enable
ce_2  in  1  phase-2 clock enable
hldrq  in  1  external hold request
buslock  in  1  EU bus-lock prefix active
dp_req  in  1  EU data-pointer request (level, held until dp_ack)
dp_ack  out  1  one-ce_2 pulse when the data cycle completes
pfp_new  in  16  new prefetch pointer
pfp_set  in  1  load pfp_new and flush (sampled on ce_1)
ipq_used  in  4  bytes currently in the queue
cyc_start  out  1  one-ce_2 pulse: engine begins T1
cyc_kind  out  1  0=FETCH, 1=DATA; valid with cyc_start, held until cyc_done
fetch_addr  out  16  PS offset for the fetch cycle
fetch_width  out  2  bytes requested by the fetch: 1 if fetch_addr odd, else 2
cyc_done  in  1  engine completed the current cycle (ce_2-aligned)
fetch_discard  out  1  with cyc_done on FETCH: data must not enter the queue
hldak  out  1  hold acknowledge

Behaviour:
- All state updates occur on clk edges with ce_2=1, except pfp_set/pfp_new, which are captured on ce_1. Inputs are ignored when no enable is high.
- Reset values: state=S_IDLE, hldak=0, cyc_start=0, cyc_kind=0, dp_ack=0, fetch_discard=0, fetch_addr=0, inflight=0, discard_pend=0.
- Reset mid-cycle abandons the cycle. No dp_ack is generated.
- States:
  - S_IDLE: evaluated each ce_2. Priority: hold > data > fetch.
    - hldrq & ~buslock -> S_HOLD, hldak=1.
    - Else dp_req -> S_DATA, cyc_start=1, cyc_kind=1.
    - Else fetch_ok -> S_FETCH, cyc_start=1, cyc_kind=0, inflight=fetch_width.
  - S_DATA: wait for cyc_done. Then dp_ack=1 for one ce_2 and return to S_IDLE. Arbitration restarts on the following ce_2, so there is no back-to-back start on the done edge.
  - S_FETCH: wait for cyc_done, then go to S_IDLE.
    - If discard_pend=0: fetch_addr += fetch_width (16-bit wrap, 0xFFFF+1=0x0000).
    - If discard_pend=1: fetch_discard=1 with the done edge, fetch_addr is unchanged, discard_pend is cleared.
    - inflight is cleared in both cases.
  - S_HOLD: hldak stays 1 while hldrq=1. On hldrq=0: hldak=0 and go to S_HOLD_EXIT.
  - S_HOLD_EXIT: one idle ce_2, no cycle start, then S_IDLE.
- fetch_ok = (QUEUE_DEPTH - ipq_used - inflight) >= FETCH_MIN_FREE, with pfp_set not pending. Compute in 5 bits; a negative result counts as not ok.
- pfp_set on ce_1:
  - fetch_addr <= pfp_new.
  - If state is S_FETCH, set discard_pend.
  - pfp_set coinciding with a cyc_done edge: the discard applies to the completing fetch, and the pfp_new load wins over the increment.
- buslock=1 blocks a hold grant only. A hold already granted is not revoked.
- hldrq asserted while a cycle is in progress is granted at the first S_IDLE ce_2 after completion.
- dp_req dropped before it is granted is a protocol violation. Behaviour is undefined, and the bench flags it.
- cyc_start is never asserted while hldak=1.

Decomposition:
- Shared package (nec_bus_pkg): state enum {S_IDLE, S_FETCH, S_DATA, S_HOLD, S_HOLD_EXIT}, cycle-kind enum {CYC_FETCH, CYC_DATA}, QUEUE_DEPTH default.
- One sub-module, prefetch_pointer: owns fetch_addr, fetch_width, the pfp_set load, the increment and discard_pend. The arbiter FSM stays in the top.

Test Plan:
- Reset, ipq_used=0, no requests -> first ce_2: cyc_start=1, cyc_kind=0, fetch_addr=0x0000, fetch_width=2. After cyc_done, fetch_addr=0x0002.
- ipq_used=7, idle -> no cyc_start. Drop ipq_used to 6 -> fetch starts on the next ce_2.
- dp_req and fetch_ok on the same ce_2 -> DATA granted (cyc_kind=1). cyc_done -> dp_ack pulse, then fetch starts one ce_2 later.
- pfp_set with pfp_new=0x1235 during a FETCH -> cyc_done accompanied by fetch_discard=1. Next fetch: fetch_addr=0x1235, width=1; afterwards fetch_addr=0x1236.
- hldrq=1 mid-DATA -> hldak=1 only after cyc_done. With buslock=1 -> hldak stays 0 until buslock=0. hldrq=0 -> hldak=0, then one idle ce_2 before the next cyc_start.
- fetch_addr=0xFFFE, width 2, cyc_done -> fetch_addr=0x0000. Reset asserted mid-FETCH -> all outputs at reset values next edge, no dp_ack.

Source files
------------

// File: rtl/nec_bus_pkg.sv
// Shared types and defaults for the bus control unit request arbiter.
package nec_bus_pkg;

  localparam int QUEUE_DEPTH_DEF    = 8;
  localparam int FETCH_MIN_FREE_DEF = 2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DATA      = 3'd2,
    S_HOLD      = 3'd3,
    S_HOLD_EXIT = 3'd4
  } arb_state_e;

  typedef enum logic {
    CYC_FETCH = 1'b0,
    CYC_DATA  = 1'b1
  } cyc_kind_e;

  // An odd address only has one byte left in its word, so fetch a single byte.
  function automatic logic [1:0] fetch_width_of(input logic [15:0] addr);
    return addr[0] ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/prefetch_pointer.sv
// Prefetch pointer: owns the fetch address, its width, redirect loads and the
// discard bookkeeping for a fetch that was overtaken by a redirect.
module prefetch_pointer
  import nec_bus_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_1,
  input  logic        ce_2,
  input  logic        pfp_set,
  input  logic [15:0] pfp_new,
  input  logic        in_fetch,
  input  logic        fetch_done,
  output logic [15:0] fetch_addr,
  output logic [1:0]  fetch_width,
  output logic        discard_pend,
  output logic        fetch_discard
);

  logic [15:0] fetch_addr_q, fetch_addr_d;
  logic        discard_pend_q, discard_pend_d;
  logic        fetch_discard_q, fetch_discard_d;
  logic        pfp_load;
  logic        discard_hit;

  assign pfp_load    = ce_1 & pfp_set;
  // A redirect landing on the done edge still poisons the completing fetch.
  assign discard_hit = discard_pend_q | (pfp_load & in_fetch);

  // Next pointer: a redirect load wins over the post-fetch increment.
  always_comb begin
    fetch_addr_d    = fetch_addr_q;
    discard_pend_d  = discard_pend_q;
    fetch_discard_d = fetch_discard_q;
    if (ce_2) fetch_discard_d = fetch_done & discard_hit;
    if (pfp_load)
      fetch_addr_d = pfp_new;
    else if (fetch_done && !discard_hit)
      fetch_addr_d = fetch_addr_q + 16'(fetch_width_of(fetch_addr_q));
    if (fetch_done)
      discard_pend_d = 1'b0;
    else if (pfp_load && in_fetch)
      discard_pend_d = 1'b1;
  end

  // Pointer state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_addr_q    <= 16'h0000;
      discard_pend_q  <= 1'b0;
      fetch_discard_q <= 1'b0;
    end else begin
      fetch_addr_q    <= fetch_addr_d;
      discard_pend_q  <= discard_pend_d;
      fetch_discard_q <= fetch_discard_d;
    end
  end

  assign fetch_addr    = fetch_addr_q;
  assign fetch_width   = fetch_width_of(fetch_addr_q);
  assign discard_pend  = discard_pend_q;
  assign fetch_discard = fetch_discard_q;

endmodule

// File: rtl/bus_request_arbiter.sv
// Bus request arbiter: picks hold, EU data or prefetch for the bus cycle
// engine, one decision per ce_2 while idle (hold > data > fetch).
module bus_request_arbiter
  import nec_bus_pkg::*;
#(
  parameter int QUEUE_DEPTH    = QUEUE_DEPTH_DEF,
  parameter int FETCH_MIN_FREE = FETCH_MIN_FREE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_1,
  input  logic        ce_2,
  input  logic        hldrq,
  input  logic        buslock,
  input  logic        dp_req,
  output logic        dp_ack,
  input  logic [15:0] pfp_new,
  input  logic        pfp_set,
  input  logic [3:0]  ipq_used,
  output logic        cyc_start,
  output logic        cyc_kind,
  output logic [15:0] fetch_addr,
  output logic [1:0]  fetch_width,
  input  logic        cyc_done,
  output logic        fetch_discard,
  output logic        hldak
);

  arb_state_e state_q, state_d;
  cyc_kind_e  cyc_kind_q, cyc_kind_d;
  logic       cyc_start_q, cyc_start_d;
  logic       dp_ack_q, dp_ack_d;
  logic       hldak_q, hldak_d;
  logic [1:0] inflight_q, inflight_d;

  logic       in_fetch;
  logic       fetch_done;
  logic       discard_pend;
  logic       pfp_pending;
  logic [4:0] free_bytes;
  logic       fetch_ok;

  assign in_fetch    = (state_q == S_FETCH);
  assign fetch_done  = ce_2 & cyc_done & in_fetch;
  assign pfp_pending = (ce_1 & pfp_set) | discard_pend;

  prefetch_pointer u_pfp (
    .clk           (clk),
    .reset         (reset),
    .ce_1          (ce_1),
    .ce_2          (ce_2),
    .pfp_set       (pfp_set),
    .pfp_new       (pfp_new),
    .in_fetch      (in_fetch),
    .fetch_done    (fetch_done),
    .fetch_addr    (fetch_addr),
    .fetch_width   (fetch_width),
    .discard_pend  (discard_pend),
    .fetch_discard (fetch_discard)
  );

  // Queue room check; bit 4 set means the subtraction went negative.
  always_comb begin
    free_bytes = 5'(QUEUE_DEPTH) - {1'b0, ipq_used} - {3'b000, inflight_q};
    fetch_ok   = !free_bytes[4] && (free_bytes >= 5'(FETCH_MIN_FREE)) && !pfp_pending;
  end

  // Arbiter next state and registered outputs; pulses clear on every ce_2.
  always_comb begin
    state_d     = state_q;
    cyc_start_d = cyc_start_q;
    cyc_kind_d  = cyc_kind_q;
    dp_ack_d    = dp_ack_q;
    hldak_d     = hldak_q;
    inflight_d  = inflight_q;
    if (ce_2) begin
      cyc_start_d = 1'b0;
      dp_ack_d    = 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (hldrq && !buslock) begin
            state_d = S_HOLD;
            hldak_d = 1'b1;
          end else if (dp_req) begin
            state_d     = S_DATA;
            cyc_start_d = 1'b1;
            cyc_kind_d  = CYC_DATA;
          end else if (fetch_ok) begin
            state_d     = S_FETCH;
            cyc_start_d = 1'b1;
            cyc_kind_d  = CYC_FETCH;
            inflight_d  = fetch_width;
          end
        end
        S_DATA: begin
          if (cyc_done) begin
            dp_ack_d = 1'b1;
            state_d  = S_IDLE;
          end
        end
        S_FETCH: begin
          if (cyc_done) begin
            inflight_d = 2'd0;
            state_d    = S_IDLE;
          end
        end
        S_HOLD: begin
          if (!hldrq) begin
            hldak_d = 1'b0;
            state_d = S_HOLD_EXIT;
          end
        end
        S_HOLD_EXIT: state_d = S_IDLE;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cyc_start_q <= 1'b0;
      cyc_kind_q  <= CYC_FETCH;
      dp_ack_q    <= 1'b0;
      hldak_q     <= 1'b0;
      inflight_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      cyc_start_q <= cyc_start_d;
      cyc_kind_q  <= cyc_kind_d;
      dp_ack_q    <= dp_ack_d;
      hldak_q     <= hldak_d;
      inflight_q  <= inflight_d;
    end
  end

  assign cyc_start = cyc_start_q;
  assign cyc_kind  = cyc_kind_q;
  assign dp_ack    = dp_ack_q;
  assign hldak     = hldak_q;

endmodule

// File: tb/tb_bus_request_arbiter.sv
// Bench for bus_request_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a transaction model.
module tb_bus_request_arbiter;

  logic        clk = 1'b0;
  logic        reset, ce_1, ce_2, hldrq, buslock, dp_req, dp_ack, pfp_set;
  logic        cyc_start, cyc_kind, cyc_done, fetch_discard, hldak;
  logic [15:0] pfp_new, fetch_addr;
  logic [3:0]  ipq_used;
  logic [1:0]  fetch_width;

  int errs = 0, checks = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  bus_request_arbiter dut (
    .clk(clk), .reset(reset), .ce_1(ce_1), .ce_2(ce_2), .hldrq(hldrq),
    .buslock(buslock), .dp_req(dp_req), .dp_ack(dp_ack), .pfp_new(pfp_new),
    .pfp_set(pfp_set), .ipq_used(ipq_used), .cyc_start(cyc_start),
    .cyc_kind(cyc_kind), .fetch_addr(fetch_addr), .fetch_width(fetch_width),
    .cyc_done(cyc_done), .fetch_discard(fetch_discard), .hldak(hldak)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      if (errs <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // bus owner: 0 = nobody, 1 = prefetch, 2 = EU data
  int m_owner, m_addr, m_infl, was_owner, q_used, room;
  bit m_hold, m_gap, m_start, m_kind, m_ack, m_disc, m_pend, load, closed;

  function automatic int wid(input int a);
    return (a % 2 == 1) ? 1 : 2;
  endfunction

  task automatic model_step();
    if (reset) begin
      m_owner = 0; m_addr = 0; m_infl = 0; m_hold = 0; m_gap = 0;
      m_start = 0; m_kind = 0; m_ack = 0; m_disc = 0; m_pend = 0;
    end else begin
      load = ce_1 && pfp_set;
      was_owner = m_owner;
      closed = 0;
      if (ce_2) begin
        m_start = 0; m_ack = 0; m_disc = 0;
        if (m_owner == 1 && cyc_done) begin
          m_disc = m_pend || load;
          if (!m_disc) m_addr = (m_addr + wid(m_addr)) % 65536;
          m_pend = 0; m_infl = 0; m_owner = 0; closed = 1;
        end else if (m_owner == 2 && cyc_done) begin
          m_ack = 1; m_owner = 0;
        end else if (m_hold) begin
          if (!hldrq) begin m_hold = 0; m_gap = 1; end
        end else if (m_gap) begin
          m_gap = 0;
        end else if (m_owner == 0) begin
          q_used = int'(ipq_used);
          room = 8 - q_used - m_infl;
          if (hldrq && !buslock) m_hold = 1;
          else if (dp_req) begin m_owner = 2; m_start = 1; m_kind = 1; end
          else if (room >= 2 && !load && !m_pend) begin
            m_owner = 1; m_start = 1; m_kind = 0; m_infl = wid(m_addr);
          end
        end
      end
      if (load) begin
        m_addr = int'(pfp_new);
        if (was_owner == 1 && !closed) m_pend = 1;
      end
    end
  endtask

  always @(posedge clk) model_step();

  // Compare every output with the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_start",     cyc_start,     32'(m_start));
      chk("cyc_kind",      cyc_kind,      32'(m_kind));
      chk("fetch_addr",    fetch_addr,    32'(m_addr));
      chk("fetch_width",   fetch_width,   32'(wid(m_addr)));
      chk("dp_ack",        dp_ack,        32'(m_ack));
      chk("fetch_discard", fetch_discard, 32'(m_disc));
      chk("hldak",         hldak,         32'(m_hold));
      chk("start_during_hold", 32'(cyc_start & hldak), 32'd0);
    end
  end

  // Protocol monitor: dp_req may only fall once dp_ack has been given.
  logic dp_req_q = 1'b0;
  always @(posedge clk) begin
    if (chk_en && dp_req_q && !dp_req && !reset) chk("dp_req_dropped_early", 32'(dp_ack), 32'd1);
    dp_req_q <= dp_req;
  end

  task automatic tick(input bit c1, input bit c2);
    ce_1 = c1; ce_2 = c2;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic done2();
    cyc_done = 1'b1; tick(0, 1); cyc_done = 1'b0;
  endtask

  bit eng_busy;
  int eng_cnt, r;
  bit c1, c2;

  initial begin
    reset = 1; ce_1 = 0; ce_2 = 0; hldrq = 0; buslock = 0; dp_req = 0;
    pfp_set = 0; pfp_new = 0; ipq_used = 0; cyc_done = 0;
    tick(1, 1); tick(1, 1);
    chk_en = 1;
    chk("d_rst_start", cyc_start, 0); chk("d_rst_hldak", hldak, 0);
    chk("d_rst_addr", fetch_addr, 0); chk("d_rst_ack", dp_ack, 0);
    reset = 0;

    // first fetch straight out of reset
    tick(0, 1);
    chk("d_first_start", cyc_start, 1); chk("d_first_kind", cyc_kind, 0);
    chk("d_first_addr", fetch_addr, 16'h0000); chk("d_first_width", fetch_width, 2);
    done2();
    chk("d_first_done_addr", fetch_addr, 16'h0002); chk("d_first_done_start", cyc_start, 0);

    // queue nearly full holds fetches back
    ipq_used = 7; tick(0, 1); chk("d_full_a", cyc_start, 0);
    tick(0, 1); chk("d_full_b", cyc_start, 0);
    ipq_used = 6; tick(0, 1); chk("d_room_start", cyc_start, 1);
    chk("d_room_addr", fetch_addr, 16'h0002);
    done2(); ipq_used = 0;
    chk("d_room_done_addr", fetch_addr, 16'h0004);

    // data beats fetch; fetch follows one ce_2 after dp_ack
    dp_req = 1; tick(0, 1);
    chk("d_data_start", cyc_start, 1); chk("d_data_kind", cyc_kind, 1);
    tick(0, 1); chk("d_data_kind_held", cyc_kind, 1); chk("d_data_start_pulse", cyc_start, 0);
    done2(); chk("d_dp_ack", dp_ack, 1); chk("d_no_b2b_start", cyc_start, 0);
    dp_req = 0;
    tick(0, 1); chk("d_ack_pulse", dp_ack, 0);
    chk("d_fetch_after_data", cyc_start, 1); chk("d_fetch_after_data_kind", cyc_kind, 0);

    // redirect during a fetch
    pfp_set = 1; pfp_new = 16'h1235; tick(1, 0); pfp_set = 0;
    chk("d_pfp_addr", fetch_addr, 16'h1235);
    done2(); chk("d_discard", fetch_discard, 1); chk("d_discard_addr", fetch_addr, 16'h1235);
    tick(0, 1); chk("d_discard_pulse", fetch_discard, 0); chk("d_redir_start", cyc_start, 1);
    chk("d_redir_width", fetch_width, 1);
    done2(); chk("d_redir_done_addr", fetch_addr, 16'h1236);

    // hold arriving mid data cycle
    dp_req = 1; tick(0, 1); chk("d_hdata_kind", cyc_kind, 1);
    hldrq = 1; tick(0, 1); chk("d_hold_mid_data", hldak, 0);
    done2(); chk("d_hold_ack", dp_ack, 1); chk("d_hold_not_yet", hldak, 0);
    dp_req = 0;
    tick(0, 1); chk("d_hold_grant", hldak, 1); chk("d_hold_no_start", cyc_start, 0);
    hldrq = 0; tick(0, 1); chk("d_hold_release", hldak, 0);
    tick(0, 1); chk("d_hold_gap", cyc_start, 0);
    tick(0, 1); chk("d_after_hold_start", cyc_start, 1); chk("d_after_hold_addr", fetch_addr, 16'h1236);
    done2(); chk("d_after_hold_done", fetch_addr, 16'h1238);

    // buslock blocks a new grant but never revokes one
    ipq_used = 7; buslock = 1; hldrq = 1;
    tick(0, 1); chk("d_lock_a", hldak, 0);
    tick(0, 1); chk("d_lock_b", hldak, 0);
    buslock = 0; tick(0, 1); chk("d_lock_grant", hldak, 1);
    buslock = 1; tick(0, 1); chk("d_lock_no_revoke", hldak, 1);
    hldrq = 0; buslock = 0; tick(0, 1); chk("d_lock_release", hldak, 0);
    tick(0, 1); ipq_used = 0;

    // address wrap
    pfp_set = 1; pfp_new = 16'hFFFE; tick(1, 1); pfp_set = 0;
    chk("d_wrap_load", fetch_addr, 16'hFFFE); chk("d_wrap_blocked", cyc_start, 0);
    tick(0, 1); chk("d_wrap_start", cyc_start, 1); chk("d_wrap_width", fetch_width, 2);
    done2(); chk("d_wrap_addr", fetch_addr, 16'h0000);

    // reset in the middle of a fetch
    pfp_set = 1; pfp_new = 16'h0010; tick(1, 1); pfp_set = 0;
    tick(0, 1); chk("d_rf_start", cyc_start, 1); chk("d_rf_addr", fetch_addr, 16'h0010);
    tick(0, 1);
    reset = 1; tick(0, 0);
    chk("d_rf_addr0", fetch_addr, 0); chk("d_rf_start0", cyc_start, 0); chk("d_rf_kind0", cyc_kind, 0);
    reset = 0;

    // reset in the middle of a data cycle: no acknowledge
    dp_req = 1; tick(0, 1); chk("d_rd_kind", cyc_kind, 1);
    tick(0, 1);
    reset = 1; cyc_done = 1; tick(0, 1); cyc_done = 0;
    chk("d_rd_no_ack", dp_ack, 0); chk("d_rd_kind0", cyc_kind, 0);
    dp_req = 0; tick(0, 1); reset = 0;

    // randomized traffic with a simple bus engine
    eng_busy = 0; eng_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (dp_ack) dp_req = 0;
      else if (!dp_req && $urandom_range(0, 15) == 0) dp_req = 1;
      if ($urandom_range(0, 7) == 0) ipq_used = 4'($urandom_range(0, 10));
      if ($urandom_range(0, 29) == 0) hldrq = ~hldrq;
      if ($urandom_range(0, 9) == 0) buslock = ~buslock;
      pfp_set = ($urandom_range(0, 24) == 0);
      pfp_new = 16'($urandom);
      r = int'($urandom_range(0, 7));
      c1 = (r <= 2) || (r == 6);
      c2 = (r >= 3) && (r <= 6);
      cyc_done = 0;
      if (!eng_busy && cyc_start) begin eng_busy = 1; eng_cnt = int'($urandom_range(0, 3)); end
      if (eng_busy && c2) begin
        if (eng_cnt == 0) begin cyc_done = 1; eng_busy = 0; end
        else eng_cnt--;
      end
      tick(c1, c2);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
